// File: rtl/nes_joypad_ports_if.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_ports_if
// Desc     : CPU-side $4016/$4017 register bus for the joypad port block
// Revision : 1.0 - initial release
// ============================================================================
interface nes_joypad_ports_if #(
    parameter int PAD_W = 2
) ();
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             rd_en;
    logic [PAD_W-1:0] rd_sel;
    logic [7:0]       rd_data;
    logic             strobe;

    modport master (
        output wr_en, wr_data, rd_en, rd_sel,
        input  rd_data, strobe
    );

    modport slave (
        input  wr_en, wr_data, rd_en, rd_sel,
        output rd_data, strobe
    );
endinterface
`default_nettype wire

// File: rtl/nes_joypad_ports.sv
`default_nettype none
// ============================================================================
// Module   : nes_joypad_ports
// Desc     : NUM_PADS serial NES controller ports with A/B turbo and
//            opposing-direction suppression
// Revision : 1.0 - initial release
// ============================================================================
module nes_joypad_ports #(
    parameter int          NUM_PADS    = 2,
    parameter int          BUTTONS     = 8,
    parameter logic [19:0] TURBO_DIV   = 20'd416_666,
    parameter bit          OPPOSE_MASK = 1'b1,
    parameter int          PAD_W       = 2
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic [NUM_PADS*BUTTONS-1:0]   buttons_in,
    input  wire logic [2*NUM_PADS-1:0]         turbo_en,
    nes_joypad_ports_if.slave                  bus
);

    logic                  r_strobe;
    logic [7:0]            r_rd_data;
    logic [19:0]           r_turbo_cnt;
    logic                  r_turbo_phase;
    logic                  w_reload;
    logic [(1<<PAD_W)-1:0] w_lsb;
    logic                  w_unused;

    // A strobe-setting write reloads on the same edge, and so does the
    // write that clears strobe (r_strobe is still high on that edge).
    assign w_reload = r_strobe | (bus.wr_en & bus.wr_data[0]);
    assign w_unused = ^bus.wr_data[7:1];

    assign bus.strobe  = r_strobe;
    assign bus.rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_turbo_cnt   <= 20'd0;
            r_turbo_phase <= 1'b0;
        end else if (r_turbo_cnt == TURBO_DIV - 20'd1) begin
            r_turbo_cnt   <= 20'd0;
            r_turbo_phase <= ~r_turbo_phase;
        end else begin
            r_turbo_cnt   <= r_turbo_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe  <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            if (bus.wr_en) begin
                r_strobe <= bus.wr_data[0];
            end
            // Unpopulated port indices read a 0 serial bit, giving 8'h40.
            if (bus.rd_en) begin
                r_rd_data <= {7'b0100000, w_lsb[bus.rd_sel]};
            end
        end
    end

    genvar p;
    generate
        for (p = 0; p < (1 << PAD_W); p++) begin : g_pad
            if (p < NUM_PADS) begin : g_live
                logic [BUTTONS-1:0] w_raw;
                logic [BUTTONS-1:0] w_turbo;
                logic [BUTTONS-1:0] w_eff;
                logic [BUTTONS-1:0] r_sr;

                assign w_raw = buttons_in[p*BUTTONS +: BUTTONS];

                always_comb begin
                    w_turbo    = w_raw;
                    w_turbo[0] = w_raw[0] & (r_turbo_phase | ~turbo_en[2*p]);
                    w_turbo[1] = w_raw[1] & (r_turbo_phase | ~turbo_en[2*p+1]);
                end

                if (OPPOSE_MASK && (BUTTONS >= 8)) begin : g_oppose
                    always_comb begin
                        w_eff = w_turbo;
                        if (w_turbo[4] && w_turbo[5]) begin
                            w_eff[5:4] = 2'b00;
                        end
                        if (w_turbo[6] && w_turbo[7]) begin
                            w_eff[7:6] = 2'b00;
                        end
                    end
                end else begin : g_no_oppose
                    assign w_eff = w_turbo;
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_sr <= '1;
                    end else if (w_reload) begin
                        r_sr <= w_eff;
                    end else if (bus.rd_en && (bus.rd_sel == PAD_W'(p))) begin
                        r_sr <= {1'b1, r_sr[BUTTONS-1:1]};
                    end
                end

                assign w_lsb[p] = r_sr[0];
            end else begin : g_empty
                assign w_lsb[p] = 1'b0;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_nes_joypad_ports.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_joypad_ports
// Desc     : Self-checking bench for nes_joypad_ports against a button-list
//            reference model (2 pads, TURBO_DIV = 4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_joypad_ports;

    localparam int          C_PADS = 2;
    localparam int          C_BTNS = 8;
    localparam int          C_TDIV = 4;

    logic                      clk;
    logic                      reset;
    logic [C_PADS*C_BTNS-1:0]  buttons_in;
    logic [2*C_PADS-1:0]       turbo_en;

    nes_joypad_ports_if #(.PAD_W(2)) bus ();

    nes_joypad_ports #(
        .NUM_PADS    (C_PADS),
        .BUTTONS     (C_BTNS),
        .TURBO_DIV   (20'd4),
        .OPPOSE_MASK (1'b1),
        .PAD_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons_in (buttons_in),
        .turbo_en   (turbo_en),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; turbo phase is a pure function of this.
    int unsigned cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Model: each pad holds its latched button byte plus a count of reads.
    logic [7:0] m_lat [C_PADS];
    int         m_cnt [C_PADS];
    logic       m_strobe;
    logic [7:0] m_rd;

    int n_pass;
    int n_total;

    function automatic logic [7:0] model_eff(input int p, input logic ph);
        logic [7:0] b;
        b = buttons_in[p*C_BTNS +: C_BTNS];
        if (turbo_en[2*p]   && !ph) b[0] = 1'b0;
        if (turbo_en[2*p+1] && !ph) b[1] = 1'b0;
        if (b[4] && b[5]) begin b[4] = 1'b0; b[5] = 1'b0; end
        if (b[6] && b[7]) begin b[6] = 1'b0; b[7] = 1'b0; end
        return b;
    endfunction

    function automatic logic model_bit(input int p);
        if (m_cnt[p] < C_BTNS) return m_lat[p][m_cnt[p]];
        return 1'b1;
    endfunction

    // One clock with optional write/read; returns the expected held rd_data.
    task automatic cycle(input logic w, input logic [7:0] wd, input logic r,
                         input logic [1:0] sel, output logic [7:0] exp_rd);
        logic       ph;
        logic       reload;
        logic [7:0] eff [C_PADS];
        @(negedge clk);
        bus.wr_en   = w;
        bus.wr_data = wd;
        bus.rd_en   = r;
        bus.rd_sel  = sel;
        ph = ((cyc / C_TDIV) % 2) == 1;
        for (int p = 0; p < C_PADS; p++) eff[p] = model_eff(p, ph);
        reload = m_strobe || (w && wd[0]);
        if (r) m_rd = (int'(sel) < C_PADS) ? (8'h40 | {7'd0, model_bit(int'(sel))}) : 8'h40;
        for (int p = 0; p < C_PADS; p++) begin
            if (reload) begin
                m_lat[p] = eff[p];
                m_cnt[p] = 0;
            end else if (r && int'(sel) == p && m_cnt[p] < C_BTNS) begin
                m_cnt[p] = m_cnt[p] + 1;
            end
        end
        if (w) m_strobe = wd[0];
        exp_rd = m_rd;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < C_PADS; p++) begin
            m_lat[p] = 8'hFF;
            m_cnt[p] = 0;
        end
        m_strobe = 1'b0;
        m_rd     = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        buttons_in = '0;
        turbo_en   = '0;
        do_reset();
        n_total++;
        if (bus.rd_data !== 8'h00 || bus.strobe !== 1'b0) begin
            $display("FAIL reset_state: rd_data=%h strobe=%b, required rd_data=00 strobe=0",
                     bus.rd_data, bus.strobe);
        end else n_pass++;
        for (int s = 0; s < 2; s++) begin
            cycle(1'b0, 8'h00, 1'b1, 2'(s), e);
            n_total++;
            if (bus.rd_data !== 8'h41 || bus.rd_data !== e) begin
                $display("FAIL reset_read pad%0d: rd_data=%h, required 41", s, bus.rd_data);
            end else n_pass++;
        end
    endtask

    task automatic test_serial_read();
        logic [7:0] e;
        logic [8:0] seq;
        seq = 9'b1_0000_1001;
        buttons_in = 16'h0009;
        turbo_en   = '0;
        cycle(1'b1, 8'h01, 1'b0, 2'd0, e);
        n_total++;
        if (bus.strobe !== 1'b1) begin
            $display("FAIL strobe_set: strobe=%b, required 1", bus.strobe);
        end else n_pass++;
        cycle(1'b1, 8'h00, 1'b0, 2'd0, e);
        n_total++;
        if (bus.strobe !== 1'b0) begin
            $display("FAIL strobe_clear: strobe=%b, required 0", bus.strobe);
        end else n_pass++;
        buttons_in = 16'h00F6;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
            n_total++;
            if (bus.rd_data !== e || bus.rd_data !== (8'h40 | {7'd0, seq[i]})) begin
                $display("FAIL serial_read[%0d]: rd_data=%h, required %h", i, bus.rd_data,
                         8'h40 | {7'd0, seq[i]});
            end else n_pass++;
        end
    endtask

    task automatic test_interleave();
        logic [7:0] e;
        buttons_in = {8'h02, 8'h01};
        cycle(1'b1, 8'h01, 1'b0, 2'd0, e);
        cycle(1'b1, 8'h00, 1'b0, 2'd0, e);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 2'(i % 2), e);
            n_total++;
            if (bus.rd_data !== e) begin
                $display("FAIL interleave[%0d]: rd_data=%h, required %h", i, bus.rd_data, e);
            end else n_pass++;
        end
    endtask

    task automatic test_strobe_held();
        logic [7:0] e;
        buttons_in = 16'h0001;
        cycle(1'b1, 8'h01, 1'b0, 2'd0, e);
        for (int i = 0; i < 3; i++) begin
            buttons_in[0] = ~buttons_in[0];
            cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
            n_total++;
            if (bus.rd_data !== e) begin
                $display("FAIL strobe_held[%0d]: rd_data=%h, required %h", i, bus.rd_data, e);
            end else n_pass++;
        end
        cycle(1'b1, 8'h00, 1'b0, 2'd0, e);
    endtask

    task automatic test_turbo();
        logic [7:0] e;
        buttons_in = 16'h0001;
        turbo_en   = 4'b0001;
        for (int want = 0; want < 2; want++) begin
            cycle(1'b1, 8'h01, 1'b0, 2'd0, e);
            for (int k = 0; k < 16 && ((cyc / C_TDIV) % 2) != want; k++) begin
                cycle(1'b0, 8'h00, 1'b0, 2'd0, e);
            end
            cycle(1'b1, 8'h00, 1'b0, 2'd0, e);
            cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
            n_total++;
            if (bus.rd_data !== e || bus.rd_data !== (8'h40 | 8'(want))) begin
                $display("FAIL turbo_phase%0d: rd_data=%h, required %h", want, bus.rd_data,
                         8'h40 | 8'(want));
            end else n_pass++;
        end
        turbo_en = '0;
    endtask

    task automatic test_oppose_and_range();
        logic [7:0] e;
        buttons_in = {8'hC0, 8'h70};
        cycle(1'b1, 8'h01, 1'b0, 2'd0, e);
        cycle(1'b1, 8'h00, 1'b0, 2'd0, e);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
        end
        cycle(1'b0, 8'h00, 1'b1, 2'd3, e);
        n_total++;
        if (bus.rd_data !== 8'h40) begin
            $display("FAIL out_of_range_read: rd_data=%h, required 40", bus.rd_data);
        end else n_pass++;
        for (int i = 4; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
            n_total++;
            if (bus.rd_data !== e || (i == 6 && bus.rd_data !== 8'h41)) begin
                $display("FAIL oppose_read[%0d]: rd_data=%h, required %h", i, bus.rd_data, e);
            end else n_pass++;
        end
        cycle(1'b0, 8'h00, 1'b1, 2'd1, e);
        n_total++;
        if (bus.rd_data !== e || bus.rd_data !== 8'h40) begin
            $display("FAIL oppose_pad1_lr: rd_data=%h, required 40", bus.rd_data);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        buttons_in = '0;
        cycle(1'b1, 8'h01, 1'b0, 2'd0, e);
        cycle(1'b1, 8'h00, 1'b0, 2'd0, e);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
        do_reset();
        n_total++;
        if (bus.rd_data !== 8'h00) begin
            $display("FAIL reset_mid_rd_data: rd_data=%h, required 00", bus.rd_data);
        end else n_pass++;
        cycle(1'b0, 8'h00, 1'b1, 2'd0, e);
        n_total++;
        if (bus.rd_data !== 8'h41) begin
            $display("FAIL reset_mid_read: rd_data=%h, required 41", bus.rd_data);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic       w;
        logic       r;
        for (int i = 0; i < 400; i++) begin
            buttons_in = 16'($urandom);
            turbo_en   = 4'($urandom);
            w = ($urandom % 6) == 0;
            r = ($urandom % 3) != 0;
            cycle(w, 8'($urandom), r, 2'($urandom), e);
            n_total++;
            if (bus.rd_data !== e || bus.strobe !== m_strobe) begin
                $display("FAIL random[%0d]: rd_data=%h strobe=%b, required rd_data=%h strobe=%b",
                         i, bus.rd_data, bus.strobe, e, m_strobe);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        buttons_in  = '0;
        turbo_en    = '0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;
        bus.rd_sel  = 2'd0;
        test_reset();
        test_serial_read();
        test_interleave();
        test_strobe_held();
        test_turbo();
        test_oppose_and_range();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
